// File: rtl/acc_pkg.sv
// Shared types for the accelerator FPU dispatch path.
// fpnew_pkg mirrors the fpnew type subset this path uses.
package fpnew_pkg;

  typedef enum logic [3:0] {
    FMADD,
    FNMSUB,
    ADD,
    MUL,
    DIV,
    SQRT,
    SGNJ,
    MINMAX,
    CMP,
    CLASSIFY,
    F2F,
    F2I,
    I2F,
    CPKAB,
    CPKCD
  } operation_e;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    ROD = 3'b101,
    DYN = 3'b111
  } roundmode_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;

endpackage

package acc_pkg;

  localparam int ACC_DATA_WIDTH     = 32;
  localparam int ACC_REG_ADDR_WIDTH = 5;
  localparam int ACC_DEPTH          = 4;

  function automatic int tag_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef logic [tag_width(ACC_DEPTH)-1:0] tag_t;

  typedef enum logic [1:0] {
    ROB_FREE    = 2'd0,
    ROB_PENDING = 2'd1,
    ROB_DONE    = 2'd2
  } rob_state_e;

  typedef struct packed {
    rob_state_e                    state;
    logic [ACC_REG_ADDR_WIDTH-1:0] rd;
    logic [ACC_DATA_WIDTH-1:0]     result;
    fpnew_pkg::status_t            status;
  } rob_entry_t;

  typedef struct packed {
    logic [ACC_REG_ADDR_WIDTH-1:0] rd;
    logic [ACC_DATA_WIDTH-1:0]     result;
    fpnew_pkg::status_t            status;
  } wb_t;

endpackage

// File: rtl/acc_fpu_dispatch_if.sv
// Decoder, FPU and writeback signals of the FPU dispatcher.
// master: dispatcher side. slave: decoder/FPU/regfile side.
interface acc_fpu_dispatch_if
  import acc_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DEPTH          = 4
);

  localparam int TAG_WIDTH = tag_width(DEPTH);
  localparam int CNT_WIDTH = TAG_WIDTH + 1;

  logic                        in_valid_i;
  logic                        in_ready_o;
  fpnew_pkg::operation_e       in_op_i;
  logic                        in_op_mod_i;
  fpnew_pkg::roundmode_e       in_rnd_mode_i;
  logic [3*DATA_WIDTH-1:0]     in_operands_i;
  logic [REG_ADDR_WIDTH-1:0]   in_rd_i;

  logic                        fpu_req_valid_o;
  logic                        fpu_req_ready_i;
  fpnew_pkg::operation_e       fpu_req_op_o;
  logic                        fpu_req_op_mod_o;
  fpnew_pkg::roundmode_e       fpu_req_rnd_mode_o;
  logic [3*DATA_WIDTH-1:0]     fpu_req_operands_o;
  logic [TAG_WIDTH-1:0]        fpu_req_tag_o;

  logic                        fpu_resp_valid_i;
  logic                        fpu_resp_ready_o;
  logic [DATA_WIDTH-1:0]       fpu_resp_result_i;
  fpnew_pkg::status_t          fpu_resp_status_i;
  logic [TAG_WIDTH-1:0]        fpu_resp_tag_i;

  logic                        wb_valid_o;
  logic                        wb_ready_i;
  logic [REG_ADDR_WIDTH-1:0]   wb_rd_o;
  logic [DATA_WIDTH-1:0]       wb_result_o;
  fpnew_pkg::status_t          wb_status_o;

  logic [CNT_WIDTH-1:0]        outstanding_o;
  logic                        tag_err_o;

  modport master (
    input  in_valid_i,
    output in_ready_o,
    input  in_op_i,
    input  in_op_mod_i,
    input  in_rnd_mode_i,
    input  in_operands_i,
    input  in_rd_i,
    output fpu_req_valid_o,
    input  fpu_req_ready_i,
    output fpu_req_op_o,
    output fpu_req_op_mod_o,
    output fpu_req_rnd_mode_o,
    output fpu_req_operands_o,
    output fpu_req_tag_o,
    input  fpu_resp_valid_i,
    output fpu_resp_ready_o,
    input  fpu_resp_result_i,
    input  fpu_resp_status_i,
    input  fpu_resp_tag_i,
    output wb_valid_o,
    input  wb_ready_i,
    output wb_rd_o,
    output wb_result_o,
    output wb_status_o,
    output outstanding_o,
    output tag_err_o
  );

  modport slave (
    output in_valid_i,
    input  in_ready_o,
    output in_op_i,
    output in_op_mod_i,
    output in_rnd_mode_i,
    output in_operands_i,
    output in_rd_i,
    input  fpu_req_valid_o,
    output fpu_req_ready_i,
    input  fpu_req_op_o,
    input  fpu_req_op_mod_o,
    input  fpu_req_rnd_mode_o,
    input  fpu_req_operands_o,
    input  fpu_req_tag_o,
    output fpu_resp_valid_i,
    input  fpu_resp_ready_o,
    output fpu_resp_result_i,
    output fpu_resp_status_i,
    output fpu_resp_tag_i,
    input  wb_valid_o,
    output wb_ready_i,
    input  wb_rd_o,
    input  wb_result_o,
    input  wb_status_o,
    input  outstanding_o,
    input  tag_err_o
  );

endinterface

// File: rtl/acc_rob.sv
// Reorder buffer: allocate at tail, complete by tag, retire at head.
// Ports: alloc/retire strobes, response capture, head view, full, count, sticky tag_err.
module acc_rob
  import acc_pkg::*;
#(
  parameter  int DATA_WIDTH     = 32,
  parameter  int REG_ADDR_WIDTH = 5,
  parameter  int DEPTH          = 4,
  localparam int TAG_WIDTH      = tag_width(DEPTH),
  localparam int PTR_WIDTH      = TAG_WIDTH + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alloc,
  input  logic [REG_ADDR_WIDTH-1:0] alloc_rd,
  input  logic                      resp_valid,
  input  logic [TAG_WIDTH-1:0]      resp_tag,
  input  logic [DATA_WIDTH-1:0]     resp_result,
  input  fpnew_pkg::status_t        resp_status,
  input  logic                      retire,
  output logic                      head_done,
  output logic [REG_ADDR_WIDTH-1:0] head_rd,
  output logic [DATA_WIDTH-1:0]     head_result,
  output fpnew_pkg::status_t        head_status,
  output logic [TAG_WIDTH-1:0]      tail_idx,
  output logic                      full,
  output logic [PTR_WIDTH-1:0]      count,
  output logic                      tag_err
);

  rob_state_e                state_q  [DEPTH];
  logic [REG_ADDR_WIDTH-1:0] rd_q     [DEPTH];
  logic [DATA_WIDTH-1:0]     result_q [DEPTH];
  fpnew_pkg::status_t        status_q [DEPTH];

  logic [PTR_WIDTH-1:0] head_q;
  logic [PTR_WIDTH-1:0] tail_q;
  logic [TAG_WIDTH-1:0] head_idx;
  logic                 resp_hit;

  assign head_idx = head_q[TAG_WIDTH-1:0];
  assign tail_idx = tail_q[TAG_WIDTH-1:0];

  // Same index, opposite lap: every slot is allocated.
  assign full = (head_idx == tail_idx) &&
                (head_q[TAG_WIDTH] != tail_q[TAG_WIDTH]);
  assign count = tail_q - head_q;

  assign resp_hit = resp_valid &&
                    (state_q[resp_tag] == ROB_PENDING);

  assign head_done   = (state_q[head_idx] == ROB_DONE);
  assign head_rd     = rd_q[head_idx];
  assign head_result = result_q[head_idx];
  assign head_status = status_q[head_idx];

  // Alloc targets a FREE slot, a hit targets a PENDING slot and
  // retire a DONE slot, so the three writes never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      tag_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= ROB_FREE;
      end
    end else begin
      if (alloc) begin
        state_q[tail_idx] <= ROB_PENDING;
        tail_q            <= tail_q + PTR_WIDTH'(1);
      end
      if (resp_hit) begin
        state_q[resp_tag] <= ROB_DONE;
      end else if (resp_valid) begin
        tag_err <= 1'b1;
      end
      if (retire) begin
        state_q[head_idx] <= ROB_FREE;
        head_q            <= head_q + PTR_WIDTH'(1);
      end
    end
  end

  // Payload is qualified by state, so it needs no reset.
  always_ff @(posedge clk) begin
    if (alloc) begin
      rd_q[tail_idx] <= alloc_rd;
    end
    if (resp_hit) begin
      result_q[resp_tag] <= resp_result;
      status_q[resp_tag] <= resp_status;
    end
  end

endmodule

// File: rtl/acc_fpu_dispatch.sv
// Issues FPU ops tagged with a ROB slot; retires results in order.
// Ports: clk_i, rst_i (sync, active high), bus (decoder/FPU/writeback).
module acc_fpu_dispatch
  import acc_pkg::*;
#(
  parameter  int DATA_WIDTH     = 32,
  parameter  int REG_ADDR_WIDTH = 5,
  parameter  int DEPTH          = 4,
  localparam int TAG_WIDTH      = tag_width(DEPTH)
) (
  input logic              clk_i,
  input logic              rst_i,
  acc_fpu_dispatch_if.master bus
);

  logic                 full;
  logic                 alloc;
  logic                 retire;
  logic                 head_done;
  logic [TAG_WIDTH-1:0] tail_idx;

  // Full gates issue even if the head retires this cycle.
  assign bus.fpu_req_valid_o = bus.in_valid_i & ~full;
  assign bus.in_ready_o      = bus.fpu_req_ready_i & ~full;
  assign alloc               = bus.in_valid_i & bus.in_ready_o;

  assign bus.fpu_req_op_o       = bus.in_op_i;
  assign bus.fpu_req_op_mod_o   = bus.in_op_mod_i;
  assign bus.fpu_req_rnd_mode_o = bus.in_rnd_mode_i;
  assign bus.fpu_req_operands_o = bus.in_operands_i;
  assign bus.fpu_req_tag_o      = tail_idx;

  assign bus.fpu_resp_ready_o = 1'b1;

  assign bus.wb_valid_o = head_done;
  assign retire         = head_done & bus.wb_ready_i;

  acc_rob #(
    .DATA_WIDTH    (DATA_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
    .DEPTH         (DEPTH)
  ) u_rob (
    .clk        (clk_i),
    .rst        (rst_i),
    .alloc      (alloc),
    .alloc_rd   (bus.in_rd_i),
    .resp_valid (bus.fpu_resp_valid_i),
    .resp_tag   (bus.fpu_resp_tag_i),
    .resp_result(bus.fpu_resp_result_i),
    .resp_status(bus.fpu_resp_status_i),
    .retire     (retire),
    .head_done  (head_done),
    .head_rd    (bus.wb_rd_o),
    .head_result(bus.wb_result_o),
    .head_status(bus.wb_status_o),
    .tail_idx   (tail_idx),
    .full       (full),
    .count      (bus.outstanding_o),
    .tag_err    (bus.tag_err_o)
  );

endmodule

// File: tb/tb_acc_fpu_dispatch.sv
// Bench for acc_fpu_dispatch: issue-order queue model plus
// directed scenarios and a randomized traffic phase.
module tb_acc_fpu_dispatch;

  localparam int DW    = 32;
  localparam int RW    = 5;
  localparam int DEPTH = 4;
  localparam int TW    = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  acc_fpu_dispatch_if #(
    .DATA_WIDTH    (DW),
    .REG_ADDR_WIDTH(RW),
    .DEPTH         (DEPTH)
  ) bus ();

  acc_fpu_dispatch #(
    .DATA_WIDTH    (DW),
    .REG_ADDR_WIDTH(RW),
    .DEPTH         (DEPTH)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  // Model: outstanding ops in issue order.
  typedef struct {
    int            tag;
    logic [RW-1:0] rd;
    bit            done;
    logic [DW-1:0] res;
    logic [4:0]    st;
  } ent_t;

  ent_t q[$];
  int   tail_cnt;
  bit   m_err;
  int   n_chk;
  int   n_pass;

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  // Per-cycle compare against the model, then advance the model
  // over the coming rising edge.
  bit   e_full;
  bit   e_wbv;
  bit   m_acc;
  bit   m_ret;
  int   hit;
  ent_t e;

  always @(negedge clk) begin
    #2;
    e_full = (q.size() == DEPTH);
    e_wbv  = (q.size() > 0) && q[0].done;
    chk("in_ready", 128'(bus.in_ready_o),
        128'(bus.fpu_req_ready_i & !e_full));
    chk("req_valid", 128'(bus.fpu_req_valid_o),
        128'(bus.in_valid_i & !e_full));
    chk("req_tag", 128'(bus.fpu_req_tag_o),
        128'(tail_cnt % DEPTH));
    if (bus.in_valid_i) begin
      chk("req_operands", 128'(bus.fpu_req_operands_o),
          128'(bus.in_operands_i));
      chk("req_op", 128'({bus.fpu_req_op_o,
                          bus.fpu_req_op_mod_o,
                          bus.fpu_req_rnd_mode_o}),
          128'({bus.in_op_i, bus.in_op_mod_i,
                bus.in_rnd_mode_i}));
    end
    chk("resp_ready", 128'(bus.fpu_resp_ready_o), 128'(1));
    chk("wb_valid", 128'(bus.wb_valid_o), 128'(e_wbv));
    if (e_wbv) begin
      chk("wb_rd", 128'(bus.wb_rd_o), 128'(q[0].rd));
      chk("wb_result", 128'(bus.wb_result_o), 128'(q[0].res));
      chk("wb_status", 128'(bus.wb_status_o), 128'(q[0].st));
    end
    chk("outstanding", 128'(bus.outstanding_o),
        128'(q.size()));
    chk("tag_err", 128'(bus.tag_err_o), 128'(m_err));

    if (rst) begin
      q.delete();
      tail_cnt = 0;
      m_err    = 1'b0;
    end else begin
      m_acc = bus.in_valid_i && bus.fpu_req_ready_i && !e_full;
      m_ret = e_wbv && bus.wb_ready_i;
      if (bus.fpu_resp_valid_i) begin
        hit = -1;
        foreach (q[i]) begin
          if (q[i].tag == int'(bus.fpu_resp_tag_i) && !q[i].done)
            hit = i;
        end
        if (hit < 0) begin
          m_err = 1'b1;
        end else begin
          e      = q[hit];
          e.done = 1'b1;
          e.res  = bus.fpu_resp_result_i;
          e.st   = bus.fpu_resp_status_i;
          q[hit] = e;
        end
      end
      if (m_ret) void'(q.pop_front());
      if (m_acc) begin
        e.tag  = tail_cnt % DEPTH;
        e.rd   = bus.in_rd_i;
        e.done = 1'b0;
        e.res  = '0;
        e.st   = '0;
        q.push_back(e);
        tail_cnt++;
      end
    end
  end

  task automatic nc();
    @(negedge clk);
    rst                  = 1'b0;
    bus.in_valid_i       = 1'b0;
    bus.fpu_resp_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    nc();
    rst = 1'b1;
  endtask

  task automatic set_issue(input logic [RW-1:0] rd,
                           input logic [3*DW-1:0] ops);
    bus.in_valid_i    = 1'b1;
    bus.in_op_i       = fpnew_pkg::ADD;
    bus.in_op_mod_i   = 1'b0;
    bus.in_rnd_mode_i = fpnew_pkg::RNE;
    bus.in_operands_i = ops;
    bus.in_rd_i       = rd;
  endtask

  task automatic set_rand_issue();
    set_issue(RW'($urandom), {$urandom, $urandom, $urandom});
    bus.in_op_i =
      fpnew_pkg::operation_e'(4'($urandom_range(0, 14)));
    bus.in_op_mod_i = 1'($urandom);
    bus.in_rnd_mode_i =
      fpnew_pkg::roundmode_e'(3'($urandom_range(0, 4)));
  endtask

  task automatic set_resp(input int tag,
                          input logic [DW-1:0] r,
                          input logic [4:0] st);
    bus.fpu_resp_valid_i  = 1'b1;
    bus.fpu_resp_tag_i    = TW'(tag);
    bus.fpu_resp_result_i = r;
    bus.fpu_resp_status_i = st;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: no finish");
    $fatal(1);
  end

  int pend[$];

  initial begin
    rst                   = 1'b1;
    tail_cnt              = 0;
    m_err                 = 1'b0;
    n_chk                 = 0;
    n_pass                = 0;
    bus.in_valid_i        = 1'b0;
    bus.in_op_i           = fpnew_pkg::ADD;
    bus.in_op_mod_i       = 1'b0;
    bus.in_rnd_mode_i     = fpnew_pkg::RNE;
    bus.in_operands_i     = '0;
    bus.in_rd_i           = '0;
    bus.fpu_req_ready_i   = 1'b1;
    bus.fpu_resp_valid_i  = 1'b0;
    bus.fpu_resp_result_i = '0;
    bus.fpu_resp_status_i = '0;
    bus.fpu_resp_tag_i    = '0;
    bus.wb_ready_i        = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    nc(); #3;
    chk("rst_outstanding", 128'(bus.outstanding_o), 128'(0));
    chk("rst_wb_valid", 128'(bus.wb_valid_o), 128'(0));
    chk("rst_tag_err", 128'(bus.tag_err_o), 128'(0));
    chk("rst_in_ready", 128'(bus.in_ready_o), 128'(1));

    // Single FADD, FPU answers two cycles after issue
    do_reset();
    nc();
    set_issue(5'd3, {32'h0, 32'h40000000, 32'h3F800000});
    #3;
    chk("single_tag", 128'(bus.fpu_req_tag_o), 128'(0));
    chk("single_req_op", 128'(bus.fpu_req_op_o),
        128'(fpnew_pkg::ADD));
    nc();
    nc(); set_resp(0, 32'h40400000, 5'h0);
    nc(); #3;
    chk("single_wb_valid", 128'(bus.wb_valid_o), 128'(1));
    chk("single_wb_rd", 128'(bus.wb_rd_o), 128'(3));
    chk("single_wb_result", 128'(bus.wb_result_o),
        128'(32'h40400000));
    chk("single_wb_status", 128'(bus.wb_status_o), 128'(0));
    nc(); #3;
    chk("single_drained", 128'(bus.outstanding_o), 128'(0));

    // Out-of-order responses 2,0,1
    do_reset();
    for (int i = 0; i < 3; i++) begin
      nc(); set_issue(RW'(i + 1), {$urandom, $urandom, $urandom});
    end
    nc(); set_resp(2, 32'hC2, 5'h1);
    nc(); set_resp(0, 32'hC0, 5'h0); #3;
    chk("ooo_hold_young", 128'(bus.wb_valid_o), 128'(0));
    nc(); set_resp(1, 32'hC1, 5'h0); #3;
    chk("ooo_first_rd", 128'(bus.wb_rd_o), 128'(1));
    nc(); #3;
    chk("ooo_second_rd", 128'(bus.wb_rd_o), 128'(2));
    nc(); #3;
    chk("ooo_third_rd", 128'(bus.wb_rd_o), 128'(3));
    chk("ooo_third_status", 128'(bus.wb_status_o), 128'(1));
    nc(); #3;
    chk("ooo_drained", 128'(bus.outstanding_o), 128'(0));

    // Full with writeback stalled
    do_reset();
    bus.wb_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nc(); set_issue(RW'(i + 5), {$urandom, $urandom, $urandom});
    end
    for (int i = 0; i < 4; i++) begin
      nc(); set_resp(i, 32'hA0 + i, 5'h0);
    end
    nc(); set_issue(5'd20, {$urandom, $urandom, $urandom}); #3;
    chk("full_in_ready", 128'(bus.in_ready_o), 128'(0));
    chk("full_req_valid", 128'(bus.fpu_req_valid_o), 128'(0));
    chk("full_outstanding", 128'(bus.outstanding_o), 128'(4));
    nc(); bus.wb_ready_i = 1'b1; #3;
    chk("full_first_rd", 128'(bus.wb_rd_o), 128'(5));
    nc(); #3;
    chk("full_ready_again", 128'(bus.in_ready_o), 128'(1));
    chk("full_after_retire", 128'(bus.outstanding_o), 128'(3));
    repeat (4) nc();

    // Wrap-around streaming
    do_reset();
    for (int i = 0; i < 10; i++) begin
      nc();
      set_issue(RW'(i + 1), {$urandom, $urandom, $urandom});
      if (i > 0) set_resp((i - 1) % 4, 32'h1000 + i - 1, 5'h0);
      #3;
      chk("wrap_tag", 128'(bus.fpu_req_tag_o), 128'(i % 4));
      if (i >= 2) begin
        chk("wrap_wb_valid", 128'(bus.wb_valid_o), 128'(1));
        chk("wrap_wb_result", 128'(bus.wb_result_o),
            128'(32'h1000 + i - 2));
      end
    end
    nc(); set_resp(1, 32'h1009, 5'h0);
    repeat (3) nc();
    #3;
    chk("wrap_tag_err", 128'(bus.tag_err_o), 128'(0));
    chk("wrap_drained", 128'(bus.outstanding_o), 128'(0));

    // Response to a FREE slot
    do_reset();
    nc(); set_issue(5'd7, {$urandom, $urandom, $urandom});
    nc(); set_resp(2, 32'hDEAD, 5'h1f);
    nc(); #3;
    chk("bad_tag_err", 128'(bus.tag_err_o), 128'(1));
    chk("bad_outstanding", 128'(bus.outstanding_o), 128'(1));
    chk("bad_wb_valid", 128'(bus.wb_valid_o), 128'(0));
    nc(); set_resp(0, 32'h55, 5'h0);
    nc(); #3;
    chk("bad_then_result", 128'(bus.wb_result_o), 128'(32'h55));
    chk("bad_sticky", 128'(bus.tag_err_o), 128'(1));
    nc();

    // Reset with three ops in flight
    do_reset();
    for (int i = 0; i < 3; i++) begin
      nc(); set_issue(RW'(i + 11), {$urandom, $urandom, $urandom});
    end
    nc(); rst = 1'b1;
    nc(); set_issue(5'd9, {$urandom, $urandom, $urandom}); #3;
    chk("mid_rst_outstanding", 128'(bus.outstanding_o), 128'(0));
    chk("mid_rst_wb_valid", 128'(bus.wb_valid_o), 128'(0));
    chk("mid_rst_tag", 128'(bus.fpu_req_tag_o), 128'(0));
    chk("mid_rst_tag_err", 128'(bus.tag_err_o), 128'(0));
    nc(); set_resp(1, 32'h77, 5'h0);
    nc(); #3;
    chk("late_resp_err", 128'(bus.tag_err_o), 128'(1));
    nc(); set_resp(0, 32'h78, 5'h0);
    repeat (2) nc();

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 600; c++) begin
      nc();
      bus.fpu_req_ready_i = ($urandom_range(0, 3) != 0);
      bus.wb_ready_i      = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) != 0) set_rand_issue();
      pend.delete();
      foreach (q[i]) if (!q[i].done) pend.push_back(q[i].tag);
      if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
        set_resp(pend[$urandom_range(0, pend.size() - 1)],
                 $urandom, 5'($urandom));
      end
    end
    bus.fpu_req_ready_i = 1'b1;
    bus.wb_ready_i      = 1'b1;
    for (int c = 0; c < 60 && q.size() > 0; c++) begin
      nc();
      pend.delete();
      foreach (q[i]) if (!q[i].done) pend.push_back(q[i].tag);
      if (pend.size() > 0) set_resp(pend[0], $urandom, 5'h0);
    end
    nc(); #3;
    chk("rand_drained", 128'(bus.outstanding_o), 128'(0));
    chk("rand_tag_err", 128'(bus.tag_err_o), 128'(0));

    repeat (2) nc();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/acc_fpu_dispatch.md
Name: acc_fpu_dispatch

Overview:
- Issues accelerator FPU instructions to an fpnew-style FPU and tracks up to DEPTH outstanding requests.
- Each request carries a reorder-buffer (ROB) slot index as its tag.
- Responses may return in any order; they are stored in the ROB and retired strictly in issue order to a register-writeback port.
- Sits between the accelerator instruction decoder and the FPU/register-file writeback.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- REG_ADDR_WIDTH, 5, destination register address width.
- DEPTH, 4, ROB entries / max outstanding requests; power of two, >=2.
- TAG_WIDTH, $clog2(DEPTH), width of the FPU tag; derived, not overridable.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- in_valid_i  in  1  instruction valid
- in_ready_o  out  1  instruction accepted when valid&ready
- in_op_i  in  fpnew_pkg::operation_e  FPU operation
- in_op_mod_i  in  1  operation modifier
- in_rnd_mode_i  in  fpnew_pkg::roundmode_e  rounding mode
- in_operands_i  in  3*DATA_WIDTH  operands op2,op1,op0 (op0 in LSBs)
- in_rd_i  in  REG_ADDR_WIDTH  destination register
- fpu_req_valid_o  out  1  request valid
- fpu_req_ready_i  in  1  FPU accepts request
- fpu_req_op_o / fpu_req_op_mod_o / fpu_req_rnd_mode_o / fpu_req_operands_o  out  as inputs  pass-through fields
- fpu_req_tag_o  out  TAG_WIDTH  allocated ROB slot
- fpu_resp_valid_i  in  1  response valid
- fpu_resp_ready_o  out  1  tied 1
- fpu_resp_result_i  in  DATA_WIDTH  result
- fpu_resp_status_i  in  fpnew_pkg::status_t  exception flags (5 bits)
- fpu_resp_tag_i  in  TAG_WIDTH  tag of response
- wb_valid_o  out  1  retire valid
- wb_ready_i  in  1  writeback accepts
- wb_rd_o  out  REG_ADDR_WIDTH  destination register
- wb_result_o  out  DATA_WIDTH  result
- wb_status_o  out  fpnew_pkg::status_t  flags
- outstanding_o  out  $clog2(DEPTH)+1  allocated entries count
- tag_err_o  out  1  sticky: response arrived for a non-PENDING slot

Behaviour:
- ROB: DEPTH entries, each holding state {FREE, PENDING, DONE}, rd, result and status.
- Pointers: head (retire) and tail (allocate), each TAG_WIDTH+1 bits including a wrap bit.
- Full when indices are equal and wrap bits differ; empty when head==tail.
- Issue path is combinational:
  - fpu_req_valid_o = in_valid_i & ~full.
  - in_ready_o = fpu_req_ready_i & ~full.
  - fpu_req_tag_o = tail index.
- Allocation fires on in_valid_i & in_ready_o. At that clock edge: entry[tail] <= PENDING, rd captured, tail++.
- Full blocks allocation even if the head retires in the same cycle; there is no same-cycle slot reuse.
- Response capture: on fpu_resp_valid_i, if entry[tag] is PENDING, then entry <= DONE and result/status are stored.
- Otherwise the response is dropped, tag_err_o <= 1, and tag_err_o stays set until reset.
- Retire:
  - wb_valid_o = (entry[head]==DONE).
  - wb_rd_o/wb_result_o/wb_status_o are read from entry[head].
  - On wb_valid_o & wb_ready_i: entry[head] <= FREE, head++.
- wb outputs are stable while wb_valid_o & ~wb_ready_i.
- Latency:
  - Response at cycle t yields wb_valid_o at t+1 if that entry is at head.
  - Minimum issue-to-retire latency = FPU latency + 1.
  - Throughput is one allocate, one response and one retire per cycle, all concurrently.
- Out-of-order responses: a younger DONE entry waits until all older entries retire.
- Pointer wrap: indices wrap modulo DEPTH; the wrap bit toggles on each wrap.
- outstanding_o = tail - head (counts PENDING and DONE entries).
- Reset (any cycle, including mid-operation):
  - All entries FREE; head=tail=0.
  - tag_err_o=0, wb_valid_o=0, fpu_req_valid_o follows in_valid_i, in_ready_o follows fpu_req_ready_i, outstanding_o=0.
  - In-flight FPU responses arriving after reset hit FREE slots and set tag_err_o. Upstream must flush the FPU together with this block.

Decomposition:
- Shared package (acc_pkg): rob_state_e, rob_entry_t (state, rd, result, status), wb_t struct, and a function deriving TAG_WIDTH from DEPTH.
- acc_pkg::tag_t is to be sized from the dispatcher's TAG_WIDTH for this path.
- Sub-module acc_rob: storage, pointers, full/empty and outstanding count.
- acc_fpu_dispatch instantiates acc_rob and holds the handshake glue.

Test Plan:
- Single op: issue FADD with operands 0x3F800000, 0x40000000, rd=3; FPU responds tag 0, result 0x40400000, 2 cycles later -> wb_valid_o next cycle with rd=3, result 0x40400000, status 0; outstanding_o returns to 0.
- Out-of-order: issue 3 ops with rd=1,2,3 (tags 0,1,2); responses arrive in tag order 2,0,1 -> wb order rd=1,2,3; rd=3 is not presented before rd=2 retires.
- Full/backpressure: DEPTH=4, wb_ready_i=0, 4 ops issued and all answered -> in_ready_o=0 and outstanding_o=4. Raise wb_ready_i -> one retire per cycle; in_ready_o=1 the cycle after the first retire.
- Wrap-around: stream 10 ops with immediate responses and wb_ready_i=1 -> tags cycle 0,1,2,3,0,1,...; results are retired in order with no loss; tag_err_o stays 0.
- Bad tag: response with tag 2 while slot 2 is FREE -> tag_err_o=1 and held; ROB contents and wb outputs are unchanged.
- Reset mid-op: 3 outstanding, assert rst_i for one cycle -> outstanding_o=0, wb_valid_o=0, next issue gets tag 0; a late response with tag 1 sets tag_err_o.
